// File: rtl/coh_noc_pkg.sv
// Shared types for the coherent NoC: flit payload, virtual channels and credit return.
package coh_noc_pkg;

  localparam int unsigned VC_BUFFER_DEPTH = 16;
  localparam int unsigned NUM_VC          = 4;

  typedef enum logic [1:0] {
    VC_REQ = 2'd0,
    VC_RSP = 2'd1,
    VC_DAT = 2'd2,
    VC_SNP = 2'd3
  } virtual_channel_e;

  // 611-bit flit
  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  addr;
    logic [5:0]   opcode;
    logic [7:0]   dst_id;
    logic [7:0]   src_id;
    logic [11:0]  txn_id;
    logic         last;
  } flit_t;

  typedef struct packed {
    logic             valid;
    virtual_channel_e vc;
  } credit_rtn_t;

endpackage

// File: rtl/noc_vc_fifo.sv
// Single-VC synchronous flit FIFO; a push into a full FIFO is accepted only alongside a pop.
module noc_vc_fifo
  import coh_noc_pkg::*;
#(
  parameter int unsigned DEPTH = VC_BUFFER_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  flit_t         push_data,
  input  logic          pop,
  output flit_t         head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  flit_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage is not reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/noc_vc_input_buffer.sv
// Per-port VC input buffer: per-VC FIFOs, locked round-robin output and one-cycle credit return.
module noc_vc_input_buffer
  import coh_noc_pkg::flit_t, coh_noc_pkg::virtual_channel_e, coh_noc_pkg::credit_rtn_t,
         coh_noc_pkg::VC_BUFFER_DEPTH;
#(
  parameter int unsigned DEPTH  = VC_BUFFER_DEPTH,
  parameter int unsigned NUM_VC = coh_noc_pkg::NUM_VC,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  virtual_channel_e       in_vc,
  input  flit_t                  in_flit,
  output logic                   out_valid,
  input  logic                   out_ready,
  output virtual_channel_e       out_vc,
  output flit_t                  out_flit,
  output logic                   credit_rtn_valid,
  output virtual_channel_e       credit_rtn_vc,
  output logic [NUM_VC*CW-1:0]   vc_count,
  output logic                   overflow_err
);

  flit_t            head  [NUM_VC];
  logic [CW-1:0]    cnt   [NUM_VC];
  logic [NUM_VC-1:0] full;
  logic [NUM_VC-1:0] empty;
  logic [NUM_VC-1:0] push;
  logic [NUM_VC-1:0] pop;

  logic [1:0]       rr_ptr;
  logic             lock_valid;
  virtual_channel_e lock_vc;
  credit_rtn_t      credit_q;
  logic             ovf_q;

  logic             pick_valid;
  virtual_channel_e pick_vc;
  logic             deq;

  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    assign push[i] = in_valid && (in_vc == virtual_channel_e'(i));
    assign pop[i]  = deq && (out_vc == virtual_channel_e'(i));
    assign vc_count[i*CW +: CW] = cnt[i];

    noc_vc_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[i]),
      .push_data (in_flit),
      .pop       (pop[i]),
      .head      (head[i]),
      .full      (full[i]),
      .empty     (empty[i]),
      .count     (cnt[i])
    );
  end

  // First non-empty VC at or after rr_ptr; reverse scan so the earliest hit wins.
  always_comb begin
    logic [1:0] idx;
    pick_valid = 1'b0;
    pick_vc    = virtual_channel_e'(rr_ptr);
    idx        = rr_ptr;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      idx = rr_ptr + 2'(i);
      if (!empty[idx]) begin
        pick_valid = 1'b1;
        pick_vc    = virtual_channel_e'(idx);
      end
    end
  end

  assign out_valid        = lock_valid || pick_valid;
  assign out_vc           = lock_valid ? lock_vc : pick_vc;
  assign out_flit         = head[out_vc];
  assign deq              = out_valid && out_ready;
  assign credit_rtn_valid = credit_q.valid;
  assign credit_rtn_vc    = credit_q.vc;
  assign overflow_err     = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      lock_valid <= 1'b0;
      lock_vc    <= coh_noc_pkg::VC_REQ;
      credit_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (deq) begin
        rr_ptr     <= 2'(out_vc) + 2'd1;
        lock_valid <= 1'b0;
      end else if (out_valid) begin
        // Stalled offer: freeze it so later arrivals cannot preempt.
        lock_valid <= 1'b1;
        lock_vc    <= out_vc;
      end
      credit_q.valid <= deq;
      if (deq) credit_q.vc <= out_vc;
      if (in_valid && full[in_vc] && !pop[in_vc]) ovf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// Directed table-driven bench for noc_vc_input_buffer plus fill/overflow and reset sequences.
module tb_noc_vc_input_buffer;
  import coh_noc_pkg::*;

  localparam int unsigned CW = $clog2(VC_BUFFER_DEPTH + 1);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  virtual_channel_e     in_vc;
  flit_t                in_flit;
  logic                 out_valid;
  logic                 out_ready;
  virtual_channel_e     out_vc;
  flit_t                out_flit;
  logic                 credit_rtn_valid;
  virtual_channel_e     credit_rtn_vc;
  logic [4*CW-1:0]      vc_count;
  logic                 overflow_err;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  noc_vc_input_buffer dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_vc            (in_vc),
    .in_flit          (in_flit),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_vc           (out_vc),
    .out_flit         (out_flit),
    .credit_rtn_valid (credit_rtn_valid),
    .credit_rtn_vc    (credit_rtn_vc),
    .vc_count         (vc_count),
    .overflow_err     (overflow_err)
  );

  typedef struct {
    logic             r;
    logic             iv;
    virtual_channel_e ivc;
    logic [11:0]      itx;
    logic             rdy;
    logic             ev;
    virtual_channel_e evc;
    logic [11:0]      etx;
    logic             ecv;
    virtual_channel_e ecvc;
    logic [4:0]       c0, c1, c2, c3;
    logic             eov;
  } vec_t;

  function automatic flit_t mk_flit(input logic [11:0] t);
    flit_t f;
    f        = '0;
    f.txn_id = t;
    f.src_id = t[7:0] ^ 8'h3C;
    f.dst_id = t[11:4];
    f.opcode = t[5:0];
    f.addr   = {52'h0, t} ^ 64'hA5A5_0000_F00D_0000;
    f.data   = {64{t[7:0] ^ 8'h5A}};
    f.last   = t[0];
    return f;
  endfunction

  function automatic vec_t v(input logic r, iv, input virtual_channel_e ivc, input logic [11:0] itx,
                             input logic rdy, ev, input virtual_channel_e evc, input logic [11:0] etx,
                             input logic ecv, input virtual_channel_e ecvc,
                             input logic [4:0] c0, c1, c2, c3, input logic eov);
    vec_t x;
    x.r = r; x.iv = iv; x.ivc = ivc; x.itx = itx; x.rdy = rdy;
    x.ev = ev; x.evc = evc; x.etx = etx; x.ecv = ecv; x.ecvc = ecvc;
    x.c0 = c0; x.c1 = c1; x.c2 = c2; x.c3 = c3; x.eov = eov;
    return x;
  endfunction

  // Drive one cycle's inputs at the falling edge; return at the next falling edge.
  task automatic apply(input logic r, iv, input virtual_channel_e ivc, input logic [11:0] tx,
                       input logic rdy);
    rst       = r;
    in_valid  = iv;
    in_vc     = ivc;
    in_flit   = mk_flit(tx);
    out_ready = rdy;
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic ev, input virtual_channel_e evc,
                       input logic [11:0] etx, input logic ecv, input virtual_channel_e ecvc,
                       input logic [4:0] c0, c1, c2, c3, input logic eov);
    logic ok;
    logic [4*CW-1:0] ecnt;
    ecnt = {c3, c2, c1, c0};
    ok = (out_valid === ev) && (credit_rtn_valid === ecv) && (vc_count === ecnt) &&
         (overflow_err === eov);
    if (ecv) ok = ok && (credit_rtn_vc === ecvc);
    if (ev)  ok = ok && (out_vc === evc) && (out_flit === mk_flit(etx));
    nvec++;
    if (!ok) begin
      nfail++;
      $display("FAIL %s: got valid=%0b vc=%0d txn=%h crd=%0b/%0d cnt=%h err=%0b; want valid=%0b vc=%0d txn=%h crd=%0b/%0d cnt=%h err=%0b",
               name, out_valid, out_vc, out_flit.txn_id, credit_rtn_valid, credit_rtn_vc,
               vc_count, overflow_err, ev, evc, etx, ecv, ecvc, ecnt, eov);
    end
  endtask

  vec_t vt [26];

  initial begin
    logic [11:0] nxt;

    vt[0]  = v(1,0,VC_REQ,12'h000,0, 0,VC_REQ,12'h000, 0,VC_REQ, 0,0,0,0, 0);
    vt[1]  = v(0,0,VC_REQ,12'h000,0, 0,VC_REQ,12'h000, 0,VC_REQ, 0,0,0,0, 0);
    vt[2]  = v(0,1,VC_DAT,12'h123,0, 1,VC_DAT,12'h123, 0,VC_REQ, 0,0,1,0, 0);
    vt[3]  = v(0,0,VC_REQ,12'h000,1, 0,VC_REQ,12'h000, 1,VC_DAT, 0,0,0,0, 0);
    vt[4]  = v(0,0,VC_REQ,12'h000,0, 0,VC_REQ,12'h000, 0,VC_REQ, 0,0,0,0, 0);
    vt[5]  = v(1,0,VC_REQ,12'h000,0, 0,VC_REQ,12'h000, 0,VC_REQ, 0,0,0,0, 0);
    vt[6]  = v(0,1,VC_REQ,12'h101,0, 1,VC_REQ,12'h101, 0,VC_REQ, 1,0,0,0, 0);
    vt[7]  = v(0,1,VC_SNP,12'h301,0, 1,VC_REQ,12'h101, 0,VC_REQ, 1,0,0,1, 0);
    vt[8]  = v(0,1,VC_RSP,12'h201,0, 1,VC_REQ,12'h101, 0,VC_REQ, 1,1,0,1, 0);
    vt[9]  = v(0,1,VC_REQ,12'h102,0, 1,VC_REQ,12'h101, 0,VC_REQ, 2,1,0,1, 0);
    vt[10] = v(0,1,VC_RSP,12'h202,0, 1,VC_REQ,12'h101, 0,VC_REQ, 2,2,0,1, 0);
    vt[11] = v(0,1,VC_SNP,12'h302,0, 1,VC_REQ,12'h101, 0,VC_REQ, 2,2,0,2, 0);
    vt[12] = v(0,0,VC_REQ,12'h000,1, 1,VC_RSP,12'h201, 1,VC_REQ, 1,2,0,2, 0);
    vt[13] = v(0,0,VC_REQ,12'h000,1, 1,VC_SNP,12'h301, 1,VC_RSP, 1,1,0,2, 0);
    vt[14] = v(0,0,VC_REQ,12'h000,1, 1,VC_REQ,12'h102, 1,VC_SNP, 1,1,0,1, 0);
    vt[15] = v(0,0,VC_REQ,12'h000,1, 1,VC_RSP,12'h202, 1,VC_REQ, 0,1,0,1, 0);
    vt[16] = v(0,0,VC_REQ,12'h000,1, 1,VC_SNP,12'h302, 1,VC_RSP, 0,0,0,1, 0);
    vt[17] = v(0,0,VC_REQ,12'h000,1, 0,VC_REQ,12'h000, 1,VC_SNP, 0,0,0,0, 0);
    vt[18] = v(0,0,VC_REQ,12'h000,0, 0,VC_REQ,12'h000, 0,VC_REQ, 0,0,0,0, 0);
    vt[19] = v(0,1,VC_SNP,12'h311,0, 1,VC_SNP,12'h311, 0,VC_REQ, 0,0,0,1, 0);
    vt[20] = v(0,1,VC_REQ,12'h111,0, 1,VC_SNP,12'h311, 0,VC_REQ, 1,0,0,1, 0);
    vt[21] = v(0,0,VC_REQ,12'h000,1, 1,VC_REQ,12'h111, 1,VC_SNP, 1,0,0,0, 0);
    vt[22] = v(0,1,VC_REQ,12'h112,1, 1,VC_REQ,12'h112, 1,VC_REQ, 1,0,0,0, 0);
    vt[23] = v(0,1,VC_DAT,12'h221,1, 1,VC_DAT,12'h221, 1,VC_REQ, 0,0,1,0, 0);
    vt[24] = v(0,0,VC_REQ,12'h000,1, 0,VC_REQ,12'h000, 1,VC_DAT, 0,0,0,0, 0);
    vt[25] = v(0,0,VC_REQ,12'h000,0, 0,VC_REQ,12'h000, 0,VC_REQ, 0,0,0,0, 0);

    rst = 1'b1; in_valid = 1'b0; in_vc = VC_REQ; in_flit = '0; out_ready = 1'b0;
    @(negedge clk);

    foreach (vt[i]) begin
      apply(vt[i].r, vt[i].iv, vt[i].ivc, vt[i].itx, vt[i].rdy);
      check($sformatf("vec%0d", i), vt[i].ev, vt[i].evc, vt[i].etx, vt[i].ecv, vt[i].ecvc,
            vt[i].c0, vt[i].c1, vt[i].c2, vt[i].c3, vt[i].eov);
    end

    // Fill REQ to capacity.
    apply(1, 0, VC_REQ, 12'h000, 0);
    check("fill_rst", 0, VC_REQ, 12'h000, 0, VC_REQ, 0,0,0,0, 0);
    for (int i = 0; i < 16; i++) begin
      apply(0, 1, VC_REQ, 12'h400 + 12'(i), 0);
      check($sformatf("fill%0d", i), 1, VC_REQ, 12'h400, 0, VC_REQ, 5'(i + 1),0,0,0, 0);
    end

    // Full with simultaneous same-VC write and dequeue: accepted, no error.
    apply(0, 1, VC_REQ, 12'h410, 1);
    check("full_wr_deq", 1, VC_REQ, 12'h401, 1, VC_REQ, 16,0,0,0, 0);

    // Write to full VC without dequeue: dropped, sticky error.
    apply(0, 1, VC_REQ, 12'h4FF, 0);
    check("overflow", 1, VC_REQ, 12'h401, 0, VC_REQ, 16,0,0,0, 1);
    apply(0, 0, VC_REQ, 12'h000, 0);
    check("overflow_sticky", 1, VC_REQ, 12'h401, 0, VC_REQ, 16,0,0,0, 1);

    // Drain: order 0x401..0x40F then 0x410; the dropped 0x4FF must never appear.
    for (int k = 0; k < 16; k++) begin
      nxt = (k < 14) ? 12'h402 + 12'(k) : 12'h410;
      apply(0, 0, VC_REQ, 12'h000, 1);
      check($sformatf("drain%0d", k), (k < 15), VC_REQ, nxt, 1, VC_REQ, 5'(15 - k),0,0,0, 1);
    end
    apply(0, 0, VC_REQ, 12'h000, 0);
    check("drain_idle", 0, VC_REQ, 12'h000, 0, VC_REQ, 0,0,0,0, 1);

    // Reset mid-traffic with a dequeue requested in the reset cycle.
    apply(1, 0, VC_REQ, 12'h000, 0);
    check("mid_rst_clear_err", 0, VC_REQ, 12'h000, 0, VC_REQ, 0,0,0,0, 0);
    apply(0, 1, VC_REQ, 12'h501, 0);
    apply(0, 1, VC_RSP, 12'h502, 0);
    apply(0, 1, VC_DAT, 12'h503, 0);
    apply(0, 1, VC_SNP, 12'h504, 0);
    apply(0, 1, VC_REQ, 12'h505, 0);
    check("mid_loaded", 1, VC_REQ, 12'h501, 0, VC_REQ, 2,1,1,1, 0);
    apply(1, 0, VC_REQ, 12'h000, 1);
    check("mid_rst", 0, VC_REQ, 12'h000, 0, VC_REQ, 0,0,0,0, 0);
    apply(0, 0, VC_REQ, 12'h000, 1);
    check("mid_rst_after", 0, VC_REQ, 12'h000, 0, VC_REQ, 0,0,0,0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/noc_vc_input_buffer.md
# noc_vc_input_buffer

Per-port virtual-channel input buffer for the coherent NoC router. It sits directly downstream of the link that delivers `flit_t` flits tagged with a `virtual_channel_e` (REQ/RSP/DAT/SNP). It stores each flit in a per-VC FIFO and presents one flit at a time to the router's route/switch stage through a round-robin, valid/ready output. It returns one credit per dequeued flit to the upstream sender, so credit-based flow control stays lossless.

## Interface
- `DEPTH`, default `VC_BUFFER_DEPTH` (16): entries per VC FIFO; power of two, ≥2.
- `NUM_VC`, default 4: number of VCs, fixed to match `virtual_channel_e`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  flit present on `in_flit` this cycle (no ready; credit-governed).
- `in_vc`  in  2  `virtual_channel_e` of incoming flit.
- `in_flit`  in  $bits(flit_t)=611  incoming flit.
- `out_valid`  out  1  a buffered flit is offered.
- `out_ready`  in  1  downstream accepts the offered flit.
- `out_vc`  out  2  VC of offered flit.
- `out_flit`  out  611  offered flit (head of selected VC FIFO).
- `credit_rtn_valid`  out  1  one credit returned this cycle.
- `credit_rtn_vc`  out  2  VC of returned credit.
- `vc_count`  out  NUM_VC×$clog2(DEPTH+1)  per-VC occupancy, VC0 in LSBs.
- `overflow_err`  out  1  sticky; set when a write targets a full VC.

## Operation
- Write: `in_valid`=1 pushes `in_flit` into FIFO[`in_vc`]. The write is accepted if the FIFO is not full, or if it is full and the same VC is dequeued in the same cycle (net count unchanged).
- Overflow: a write to a full FIFO with no same-VC dequeue drops the flit and sets `overflow_err`. `overflow_err` stays set until `rst`.
- Arbitration: round-robin over non-empty VCs. The search starts at `rr_ptr`, wraps mod 4, and takes the first non-empty VC. `out_valid` = any VC selected.
- Lock: while `out_valid`=1 and `out_ready`=0, `out_vc` and `out_flit` must stay stable. The selection is held in a lock register, and newly non-empty VCs do not preempt it.
- Dequeue: `out_valid && out_ready` pops FIFO[`out_vc`], sets `rr_ptr` = `out_vc`+1 mod 4 and clears the lock.
- Credit: every dequeue produces `credit_rtn_valid`=1 with `credit_rtn_vc` = dequeued VC on the next cycle. At most one credit is returned per cycle.
- No bypass: a flit written into an empty FIFO is never offered in its write cycle.
- FIFO pointers are $clog2(DEPTH) bits and wrap naturally. Count is $clog2(DEPTH+1) bits; full = (count==DEPTH).

## Timing
- Reset values: `out_valid`=0, `credit_rtn_valid`=0, `credit_rtn_vc`=0, `overflow_err`=0, all `vc_count`=0, `rr_ptr`=0 (search order REQ,RSP,DAT,SNP), lock cleared.
- `out_flit`/`out_vc` are don't-care while `out_valid`=0.
- Input-to-output latency: 1 cycle. A flit written at edge N is offerable in cycle N+1.
- Dequeue-to-credit latency: 1 cycle, registered.
- `vc_count` is registered and reflects writes and dequeues from the previous edge.
- Back-to-back dequeues: 1 per cycle sustained. With a single non-empty VC, that VC is reselected every cycle.
- Reset mid-operation: all buffered flits are discarded and no credits are returned for them. A credit pending from the cycle before `rst` is also dropped.
- Simultaneous write and dequeue on different VCs: both complete, each count changes by ±1 independently.

## Structure
- Package `coh_noc_pkg` gains `NUM_VC = 4` and `credit_rtn_t` (struct: `valid`, `vc`). It reuses `flit_t`, `virtual_channel_e` and `VC_BUFFER_DEPTH`.
- Sub-module `noc_vc_fifo`: single-VC synchronous FIFO (`DEPTH`, `flit_t` payload, push/pop/full/empty/count, push accepted when full if pop is asserted). Instantiate it `NUM_VC` times.
- The top holds the round-robin arbiter, lock register, credit register and overflow flag.

## Test plan
- Reset then idle: after `rst`, check `out_valid`=0, `credit_rtn_valid`=0, all `vc_count`=0 and `overflow_err`=0.
- Single flit: write DAT flit with `txn_id`=0x123 at cycle 0. Expect `out_valid`=1, `out_vc`=DAT and matching flit at cycle 1. With `out_ready`=1, expect `credit_rtn_valid`=1 with VC DAT at cycle 2, and `vc_count[DAT]` back to 0.
- Round-robin and lock: preload 2 flits in each of REQ, SNP and RSP with `out_ready`=0 for 3 cycles. Expect `out_vc`=REQ held stable throughout. Then `out_ready`=1 yields order REQ, RSP, SNP, REQ, RSP, SNP.
- Fill and overflow: write 16 REQ flits (`vc_count[REQ]`=16), then a 17th with no dequeue. Expect it dropped, `overflow_err`=1 (sticky) and count still 16.
- Full plus simultaneous write and dequeue: REQ full, write REQ while dequeuing REQ. Expect the write accepted, count stays 16, no error, and one credit for REQ the next cycle.
- Reset mid-traffic: assert `rst` with 5 flits buffered and a dequeue in progress. Expect no credit next cycle, all counts 0 and `out_valid`=0.
